// File: rtl/reg_file_sb.sv
// Multi-read-port register file with registered reads, write-to-read forwarding,
// immediate substitution on the last read port and a busy-bit scoreboard that
// stalls decode while a source operand is still waiting for its write-back.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned IMM_W    = 4,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    input  logic                      imm_sel,
    input  logic [IMM_W-1:0]          imm_val,
    input  logic                      issue_en,
    input  logic [ADDR_W-1:0]         issue_dst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic                      rd_data_valid,
    output logic                      rd_stall,
    output logic [(2**ADDR_W)-1:0]    busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int          LAST  = int'(NUM_RD) - 1;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                     rd_data_valid_q;
    logic                     hazard;
    logic                     accept;
    logic                     wr_ok;
    logic                     issue_ok;
    logic [ADDR_W-1:0]        haz_addr;
    logic [ADDR_W-1:0]        rdp_addr;

    // Writes to a hardwired-zero r0 are dropped entirely (no data, no busy clear).
    assign wr_ok    = wr_en && !(ZERO_REG && (wr_addr == '0));
    assign issue_ok = accept && issue_en && !(ZERO_REG && (issue_dst == '0));

    // Source hazard: a busy operand stalls unless this cycle's write-back resolves it.
    always_comb begin
        hazard   = 1'b0;
        haz_addr = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            haz_addr = rd_addr[p*ADDR_W +: ADDR_W];
            if (busy_q[haz_addr]
                && !(wr_en && (wr_addr == haz_addr))
                && !((p == LAST) && imm_sel)
                && !(ZERO_REG && (haz_addr == '0))) begin
                hazard = 1'b1;
            end
        end
    end

    assign rd_stall = rd_valid && hazard;
    assign accept   = rd_valid && !hazard;

    // Read data next-state: immediate, then forwarding, then zero reg, then array.
    always_comb begin
        rd_data_d = rd_data_q;
        rdp_addr  = '0;
        if (accept) begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                rdp_addr = rd_addr[p*ADDR_W +: ADDR_W];
                if ((p == LAST) && imm_sel) begin
                    rd_data_d[p*DATA_W +: DATA_W] = DATA_W'(imm_val);
                end else if (wr_ok && (wr_addr == rdp_addr)) begin
                    rd_data_d[p*DATA_W +: DATA_W] = wr_data;
                end else if (ZERO_REG && (rdp_addr == '0)) begin
                    rd_data_d[p*DATA_W +: DATA_W] = '0;
                end else begin
                    rd_data_d[p*DATA_W +: DATA_W] = regs_q[rdp_addr];
                end
            end
        end
    end

    // Scoreboard next-state: write-back clears first so a same-cycle claim wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    // Register array; reset loads each register with its own index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard and read-port output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q          <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= accept;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with a general r0 and one with a
// hardwired-zero r0, both driven by the same stimulus.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_valid;
    logic [7:0]  rd_addr;
    logic        imm_sel;
    logic [3:0]  imm_val;
    logic        issue_en;
    logic [3:0]  issue_dst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    logic [31:0] rd_data_a, rd_data_z;
    logic        rd_data_valid_a, rd_data_valid_z;
    logic        rd_stall_a, rd_stall_z;
    logic [15:0] busy_a, busy_z;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.ZERO_REG(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .imm_sel(imm_sel), .imm_val(imm_val), .issue_en(issue_en), .issue_dst(issue_dst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_a),
        .rd_data_valid(rd_data_valid_a), .rd_stall(rd_stall_a), .busy(busy_a)
    );

    reg_file_sb #(.ZERO_REG(1'b1)) u_dut_z (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .imm_sel(imm_sel), .imm_val(imm_val), .issue_en(issue_en), .issue_dst(issue_dst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_z),
        .rd_data_valid(rd_data_valid_z), .rd_stall(rd_stall_z), .busy(busy_z)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_valid  = 1'b0;
        rd_addr   = '0;
        imm_sel   = 1'b0;
        imm_val   = '0;
        issue_en  = 1'b0;
        issue_dst = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #3;
        chk("reset rd_data a", 64'(rd_data_a), 64'h0);
        chk("reset valid a", 64'(rd_data_valid_a), 64'h0);
        chk("reset busy a", 64'(busy_a), 64'h0);
        chk("reset rd_data z", 64'(rd_data_z), 64'h0);
        chk("reset busy z", 64'(busy_z), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Plain read of r5 (port1) and r3 (port0).
        rd_valid = 1'b1;
        rd_addr  = {4'd5, 4'd3};
        #1;
        chk("read53 stall a", 64'(rd_stall_a), 64'h0);
        tick();
        chk("read53 data a", 64'(rd_data_a), 64'h0005_0003);
        chk("read53 valid a", 64'(rd_data_valid_a), 64'h1);
        chk("read53 busy a", 64'(busy_a), 64'h0);
        chk("read53 data z", 64'(rd_data_z), 64'h0005_0003);

        // Immediate on port1, r7 on port0.
        rd_addr = {4'd9, 4'd7};
        imm_sel = 1'b1;
        imm_val = 4'hA;
        tick();
        chk("imm data a", 64'(rd_data_a), 64'h000A_0007);
        chk("imm valid a", 64'(rd_data_valid_a), 64'h1);

        // Same request with a write-back to r7: forwarded.
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = 16'h1234;
        tick();
        chk("fwd data a", 64'(rd_data_a), 64'h000A_1234);
        chk("fwd data z", 64'(rd_data_z), 64'h000A_1234);

        // r7 now holds the written value.
        idle();
        rd_valid = 1'b1;
        rd_addr  = {4'd7, 4'd1};
        tick();
        chk("r7 stored a", 64'(rd_data_a), 64'h1234_0001);

        // Issue claims r2.
        rd_addr   = {4'd1, 4'd0};
        issue_en  = 1'b1;
        issue_dst = 4'd2;
        tick();
        chk("issue2 data a", 64'(rd_data_a), 64'h0001_0000);
        chk("issue2 busy a", 64'(busy_a), 64'h0004);
        chk("issue2 busy z", 64'(busy_z), 64'h0004);

        // Read of busy r2 stalls; output holds. Issue while stalled is ignored.
        rd_addr   = {4'd2, 4'd1};
        issue_dst = 4'd8;
        #1;
        chk("r2 stall a", 64'(rd_stall_a), 64'h1);
        chk("r2 stall z", 64'(rd_stall_z), 64'h1);
        tick();
        chk("stalled valid a", 64'(rd_data_valid_a), 64'h0);
        chk("stalled data a", 64'(rd_data_a), 64'h0001_0000);
        chk("stalled busy a", 64'(busy_a), 64'h0004);

        // Write-back of r2 in the stall cycle releases it and forwards.
        issue_en = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 4'd2;
        wr_data  = 16'hBEEF;
        #1;
        chk("wb stall a", 64'(rd_stall_a), 64'h0);
        tick();
        chk("wb data a", 64'(rd_data_a), 64'hBEEF_0001);
        chk("wb valid a", 64'(rd_data_valid_a), 64'h1);
        chk("wb busy a", 64'(busy_a), 64'h0);

        // Same-cycle issue and write to r4: claim wins, data stored.
        rd_addr   = {4'd1, 4'd0};
        issue_en  = 1'b1;
        issue_dst = 4'd4;
        wr_addr   = 4'd4;
        wr_data   = 16'h5555;
        tick();
        chk("iw4 busy a", 64'(busy_a), 64'h0010);
        chk("iw4 busy z", 64'(busy_z), 64'h0010);
        idle();
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        wr_data = 16'h5555;
        tick();
        chk("clr4 busy a", 64'(busy_a), 64'h0);
        idle();
        rd_valid = 1'b1;
        rd_addr  = {4'd4, 4'd4};
        imm_sel  = 1'b1;
        imm_val  = 4'h3;
        tick();
        chk("r4 data a", 64'(rd_data_a), 64'h0003_5555);

        // Hardwired zero: write r0, claim r0, read r0.
        idle();
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hFFFF;
        tick();
        idle();
        rd_valid  = 1'b1;
        rd_addr   = {4'd1, 4'd1};
        issue_en  = 1'b1;
        issue_dst = 4'd0;
        tick();
        chk("z0 issue busy z", 64'(busy_z), 64'h0);
        chk("z0 issue busy a", 64'(busy_a), 64'h0001);
        issue_en = 1'b0;
        rd_addr  = {4'd0, 4'd0};
        #1;
        chk("z0 stall z", 64'(rd_stall_z), 64'h0);
        chk("r0 stall a", 64'(rd_stall_a), 64'h1);
        tick();
        chk("z0 data z", 64'(rd_data_z), 64'h0);
        chk("z0 valid z", 64'(rd_data_valid_z), 64'h1);
        chk("z0 busy z", 64'(busy_z), 64'h0);

        // Claim r6, then asynchronous reset mid-cycle.
        rd_addr   = {4'd1, 4'd1};
        issue_en  = 1'b1;
        issue_dst = 4'd6;
        tick();
        chk("issue6 busy z", 64'(busy_z), 64'h0040);
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("async busy a", 64'(busy_a), 64'h0);
        chk("async busy z", 64'(busy_z), 64'h0);
        chk("async data z", 64'(rd_data_z), 64'h0);
        chk("async valid z", 64'(rd_data_valid_z), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        rd_valid = 1'b1;
        rd_addr  = {4'd6, 4'd0};
        tick();
        chk("r6 after reset a", 64'(rd_data_a), 64'h0006_0000);
        chk("r6 after reset z", 64'(rd_data_z), 64'h0006_0000);
        chk("r6 valid a", 64'(rd_data_valid_a), 64'h1);

        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-read-port register file for the CPU datapath, the next generation of the 16x16 register file.
- Reads are registered (1-cycle latency).
- Same-cycle write-to-read forwarding.
- Per-port immediate substitution on the last read port.
- Busy-bit scoreboard that raises a stall when a source operand has an outstanding write-back.
- Sits between decode (read/issue) and write-back (write).

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 4, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (>=1)
IMM_W, 4, immediate field width (IMM_W <= DATA_W)
ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, writes ignored, never busy)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
rd_valid  input  1  decode presents a read/issue request this cycle
rd_addr  input  NUM_RD*ADDR_W  read addresses; port p = bits [p*ADDR_W +: ADDR_W]
imm_sel  input  1  last read port (NUM_RD-1) returns the immediate instead of a register
imm_val  input  IMM_W  immediate value, zero-extended to DATA_W
issue_en  input  1  request also claims a destination (marks it busy)
issue_dst  input  ADDR_W  destination register being claimed
wr_en  input  1  write-back strobe
wr_addr  input  ADDR_W  write-back address
wr_data  input  DATA_W  write-back data
rd_data  output  NUM_RD*DATA_W  registered read data; port p = bits [p*DATA_W +: DATA_W]
rd_data_valid  output  1  rd_data holds the result of a request accepted the previous cycle
rd_stall  output  1  combinational; current request is not accepted
busy  output  2**ADDR_W  scoreboard bit per register

Behaviour:
- Reset (reset low, asynchronous):
  - registers[i] = i zero-extended to DATA_W; if ZERO_REG, registers[0] = 0.
  - busy = 0, rd_data = 0, rd_data_valid = 0.
  - A reset during an outstanding write-back discards that pending state: all busy bits clear.
- Write (posedge, wr_en=1):
  - registers[wr_addr] <= wr_data; busy[wr_addr] clears.
  - Ignored entirely when ZERO_REG=1 and wr_addr=0.
  - A write to a non-busy register is legal.
- Source operand hazard for port p:
  - Applies when rd_valid=1, busy[rd_addr_p]=1, and not (wr_en=1 and wr_addr=rd_addr_p).
  - Port NUM_RD-1 is exempt from the hazard check when imm_sel=1.
  - Register 0 is exempt when ZERO_REG=1.
- rd_stall = rd_valid AND (any port hazard).
  - Combinational from current inputs and the busy register.
- Accept: rd_valid=1 and rd_stall=0.
- On accept, at the next posedge, for each port p:
  - rd_data_p = wr_data if wr_en and wr_addr==rd_addr_p (forwarding);
  - else 0 if ZERO_REG and rd_addr_p==0;
  - else registers[rd_addr_p].
  - Port NUM_RD-1 with imm_sel=1 instead gets {zeros, imm_val}.
  - rd_data_valid <= 1.
- Not accepted (idle or stalled): rd_data holds its previous value; rd_data_valid <= 0.
- Issue:
  - On accept with issue_en=1, busy[issue_dst] sets at the posedge.
  - issue_en is ignored when not accepted.
  - Issue with ZERO_REG=1 and issue_dst=0 has no effect.
- Simultaneous issue and write to the same address in one cycle: busy ends set (the new claim wins); the write data is still stored.
- An issue claiming a register that is one of its own sources uses that register's pre-issue value. No self-stall occurs unless the register was already busy.
- Latency:
  - Read: 1 cycle from accept to rd_data_valid.
  - Write to architectural state: 1 cycle.
  - Write to a dependent read: 0 cycles (forwarding).

Test Plan:
- Reset release, then read ports rd_addr={5,3} with rd_valid=1 → next cycle rd_data={16'd5,16'd3}, rd_data_valid=1, busy=0.
- imm_sel=1, imm_val=4'hA, rd_addr={7,x} → port0=16'd7, port1=16'h000A; wr_en to addr 7 with data 16'h1234 in the same cycle → port0=16'h1234 (forwarding).
- Issue with issue_dst=2 → busy[2]=1; next read of r2 → rd_stall=1, rd_data_valid=0 next cycle, rd_data unchanged; wr_en addr 2 data 16'hBEEF in the stall cycle → stall drops the same cycle, port returns 16'hBEEF, busy[2]=0.
- Same-cycle issue_dst=4 and wr_en wr_addr=4 → registers[4] updated, busy[4]=1 afterwards.
- ZERO_REG=1: write 16'hFFFF to r0, issue_dst=0, then read r0 → returns 0, no stall, busy[0]=0.
- busy[6]=1, then reset asserted mid-cycle (asynchronous) → busy=0, rd_data=0, rd_data_valid=0 immediately; r6 reads 16'd6 after reset release.
